// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, operand-select codes and FSM states shared by the ALU subsystem.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_MUL = 3'd7;
    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_ACC  = 2'd1;
    localparam logic [1:0] SRCA_SP   = 2'd2;
    localparam logic [1:0] SRCA_ZERO = 2'd3;
    localparam logic [2:0] SRCB_INC = 3'd0;
    localparam logic [2:0] SRCB_SE  = 3'd1;
    localparam logic [2:0] SRCB_MDR = 3'd2;
    localparam logic [2:0] SRCB_ZE  = 3'd3;
    localparam logic [2:0] SRCB_SL1 = 3'd4;
    typedef enum logic {ST_IDLE, ST_MULT} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per clock.
// Ports: clk, rst (async, active high), load (latch a/b, clear accumulator, arm counter),
//        a/b operands, acc_next (accumulator value after the current step), last (current step is the final one).
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic             last
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run;
    always_comb begin
        run      = cnt_q != '0;
        acc_next = acc_q + (b_q[0] ? a_q : '0);
        last     = cnt_q == CW'(1);
        a_d      = load ? a  : run ? a_q << 1 : a_q;
        b_d      = load ? b  : run ? b_q >> 1 : b_q;
        acc_d    = load ? '0 : run ? acc_next : acc_q;
        cnt_d    = load ? CW'(WIDTH) : run ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_sub_seq.sv
// alu_sub_seq: operand muxing, 8-op ALU with iterative MUL, registered result and flags.
// Ports: CLK, reset (async, active high); PC/ACC/SP/MDR/SE/ZE/SL1 operand sources;
//        SrcA/SrcB/ALUOp selects; start request; Out (combinational result);
//        aluOut/Zero/Carry/Ovf registered result and flags; busy (MUL iterating); done (result pulse).
module alu_sub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int INC_CONST = 2,
    parameter int SHW       = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] ACC,
    input  logic [WIDTH-1:0] SP,
    input  logic [WIDTH-1:0] MDR,
    input  logic [WIDTH-1:0] SE,
    input  logic [WIDTH-1:0] ZE,
    input  logic [WIDTH-1:0] SL1,
    input  logic [1:0]       SrcA,
    input  logic [2:0]       SrcB,
    input  logic [2:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] aluOut,
    output logic             Zero,
    output logic             Carry,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);
    localparam int M = WIDTH - 1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d, a, b, diff, res, mul_next;
    logic [WIDTH:0]   sum;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;
    logic             carry_c, ovf_c, take, single, mul_load, mul_last;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst     (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .acc_next(mul_next),
        .last    (mul_last)
    );
    always_comb begin
        a = SrcA == SRCA_PC  ? PC  :
            SrcA == SRCA_ACC ? ACC :
            SrcA == SRCA_SP  ? SP  : '0;
        b = SrcB == SRCB_INC ? WIDTH'(INC_CONST) :
            SrcB == SRCB_SE  ? SE  :
            SrcB == SRCB_MDR ? MDR :
            SrcB == SRCB_ZE  ? ZE  :
            SrcB == SRCB_SL1 ? SL1 : '0;
        sum  = {1'b0, a} + {1'b0, b};
        diff = a - b;
        res = ALUOp == ALU_ADD ? sum[M:0] :
              ALUOp == ALU_SUB ? diff :
              ALUOp == ALU_AND ? a & b :
              ALUOp == ALU_OR  ? a | b :
              ALUOp == ALU_SLT ? WIDTH'($signed(a) < $signed(b)) :
              ALUOp == ALU_SLL ? a << b[SHW-1:0] :
              ALUOp == ALU_SRL ? a >> b[SHW-1:0] : '0;
        // Carry on SUB means "no borrow", i.e. A >= B unsigned.
        carry_c = ALUOp == ALU_ADD ? sum[WIDTH] : ALUOp == ALU_SUB ? a >= b : 1'b0;
        ovf_c = ALUOp == ALU_ADD ? (a[M] == b[M]) && (sum[M] != a[M]) :
                ALUOp == ALU_SUB ? (a[M] != b[M]) && (diff[M] != a[M]) : 1'b0;
        Out      = res;
        take     = state_q == ST_IDLE && start;
        single   = take && ALUOp != ALU_MUL;
        mul_load = take && ALUOp == ALU_MUL;
    end
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        if (single) begin
            alu_out_d = res;
            zero_d    = res == '0;
            carry_d   = carry_c;
            ovf_d     = ovf_c;
            done_d    = 1'b1;
        end
        if (mul_load)
            state_d = ST_MULT;
        // The final step's accumulator is committed on the same edge the counter expires.
        if (state_q == ST_MULT && mul_last) begin
            state_d   = ST_IDLE;
            alu_out_d = mul_next;
            zero_d    = mul_next == '0;
            carry_d   = 1'b0;
            ovf_d     = 1'b0;
            done_d    = 1'b1;
        end
    end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end
    assign aluOut = alu_out_q;
    assign Zero   = zero_q;
    assign Carry  = carry_q;
    assign Ovf    = ovf_q;
    assign busy   = state_q == ST_MULT;
    assign done   = done_q;
endmodule

// File: tb/tb_alu_sub_seq.sv
// tb_alu_sub_seq: directed self-checking bench for alu_sub_seq.
module tb_alu_sub_seq;
    logic        CLK = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] PC = '0, ACC = '0, SP = '0, MDR = '0, SE = '0, ZE = '0, SL1 = '0;
    logic [1:0]  SrcA = '0;
    logic [2:0]  SrcB = '0, ALUOp = '0;
    logic [15:0] Out, aluOut;
    logic        Zero, Carry, Ovf, busy, done;
    int          vectors = 0, errors = 0;

    alu_sub_seq dut (
        .CLK(CLK), .reset(reset), .PC(PC), .ACC(ACC), .SP(SP), .MDR(MDR), .SE(SE), .ZE(ZE), .SL1(SL1),
        .SrcA(SrcA), .SrcB(SrcB), .ALUOp(ALUOp), .start(start), .Out(Out), .aluOut(aluOut),
        .Zero(Zero), .Carry(Carry), .Ovf(Ovf), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic sel(input logic [2:0] op, input logic [1:0] sa, input logic [2:0] sb);
        ALUOp = op;
        SrcA  = sa;
        SrcB  = sb;
    endtask

    task automatic single(input logic [2:0] op, input logic [1:0] sa, input logic [2:0] sb);
        sel(op, sa, sb);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        PC = 16'hFFFF;
        single(3'd0, 2'd0, 3'd0);
        vectors++;
        if (aluOut !== 16'h0001 || Carry !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_add: aluOut=%h Carry=%b, want 0001 1", aluOut, Carry);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({aluOut, Zero, Carry, Ovf, busy, done} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: aluOut=%h Z=%b C=%b O=%b busy=%b done=%b, want all 0", aluOut, Zero, Carry, Ovf, busy, done);
        end
        @(negedge CLK) reset = 1'b0;
        PC = 16'h0010;
        sel(3'd0, 2'd0, 3'd0);
        #1;
        vectors++;
        if (Out !== 16'h0012) begin
            errors++;
            $display("FAIL comb_out_add: Out=%h, want 0012", Out);
        end
        single(3'd0, 2'd0, 3'd0);
        vectors++;
        if (aluOut !== 16'h0012 || done !== 1'b1 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL add_pc_inc: aluOut=%h done=%b Z=%b, want 0012 1 0", aluOut, done, Zero);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || aluOut !== 16'h0012) begin
            errors++;
            $display("FAIL hold_no_start: done=%b aluOut=%h, want 0 0012", done, aluOut);
        end
    endtask

    task automatic test_arith;
        ACC = 16'h0005; MDR = 16'h0005;
        single(3'd1, 2'd1, 3'd2);
        vectors++;
        if ({aluOut, Zero, Carry, Ovf} !== {16'h0000, 3'b110}) begin
            errors++;
            $display("FAIL sub_equal: aluOut=%h Z=%b C=%b O=%b, want 0000 1 1 0", aluOut, Zero, Carry, Ovf);
        end
        ACC = 16'h0003;
        single(3'd1, 2'd1, 3'd2);
        vectors++;
        if ({aluOut, Zero, Carry, Ovf} !== {16'hFFFE, 3'b000}) begin
            errors++;
            $display("FAIL sub_borrow: aluOut=%h Z=%b C=%b O=%b, want FFFE 0 0 0", aluOut, Zero, Carry, Ovf);
        end
        ACC = 16'h7FFF; SE = 16'h0001;
        single(3'd0, 2'd1, 3'd1);
        vectors++;
        if ({aluOut, Zero, Carry, Ovf} !== {16'h8000, 3'b001}) begin
            errors++;
            $display("FAIL add_ovf: aluOut=%h Z=%b C=%b O=%b, want 8000 0 0 1", aluOut, Zero, Carry, Ovf);
        end
        ACC = 16'h8000; MDR = 16'h0001;
        single(3'd1, 2'd1, 3'd2);
        vectors++;
        if ({aluOut, Zero, Carry, Ovf} !== {16'h7FFF, 3'b011}) begin
            errors++;
            $display("FAIL sub_ovf: aluOut=%h Z=%b C=%b O=%b, want 7FFF 0 1 1", aluOut, Zero, Carry, Ovf);
        end
    endtask

    task automatic test_logic_shift;
        ACC = 16'hFFFF; ZE = 16'h0001;
        single(3'd4, 2'd1, 3'd3);
        vectors++;
        if ({aluOut, Carry, Ovf} !== {16'h0001, 2'b00}) begin
            errors++;
            $display("FAIL slt_neg: aluOut=%h C=%b O=%b, want 0001 0 0", aluOut, Carry, Ovf);
        end
        ACC = 16'h0001; SE = 16'h0004;
        single(3'd5, 2'd1, 3'd1);
        vectors++;
        if (aluOut !== 16'h0010) begin
            errors++;
            $display("FAIL sll: aluOut=%h, want 0010", aluOut);
        end
        ACC = 16'h8000; SE = 16'h000F;
        single(3'd6, 2'd1, 3'd1);
        vectors++;
        if (aluOut !== 16'h0001) begin
            errors++;
            $display("FAIL srl: aluOut=%h, want 0001", aluOut);
        end
        ACC = 16'h0F0F; SL1 = 16'h00FF;
        single(3'd2, 2'd1, 3'd4);
        vectors++;
        if (aluOut !== 16'h000F) begin
            errors++;
            $display("FAIL and_sl1: aluOut=%h, want 000F", aluOut);
        end
        SP = 16'hF000;
        single(3'd3, 2'd2, 3'd6);
        vectors++;
        if (aluOut !== 16'hF000) begin
            errors++;
            $display("FAIL or_sp_zero: aluOut=%h, want F000", aluOut);
        end
        MDR = 16'h1234;
        single(3'd0, 2'd3, 3'd2);
        vectors++;
        if (aluOut !== 16'h1234) begin
            errors++;
            $display("FAIL add_zero_mdr: aluOut=%h, want 1234", aluOut);
        end
    endtask

    task automatic test_back_to_back;
        PC = 16'h0010; ACC = 16'h0009; MDR = 16'h0004;
        sel(3'd0, 2'd0, 3'd0);
        start = 1'b1;
        tick();
        vectors++;
        if (aluOut !== 16'h0012 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: aluOut=%h done=%b, want 0012 1", aluOut, done);
        end
        sel(3'd1, 2'd1, 3'd2);
        tick();
        start = 1'b0;
        vectors++;
        if (aluOut !== 16'h0005 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: aluOut=%h done=%b, want 0005 1", aluOut, done);
        end
    endtask

    task automatic test_mul(input logic [15:0] prev);
        ACC = 16'h0012; MDR = 16'h0034;
        single(3'd7, 2'd1, 3'd2);
        vectors++;
        if (busy !== 1'b1 || Out !== 16'h0000) begin
            errors++;
            $display("FAIL mul_start: busy=%b Out=%h, want 1 0000", busy, Out);
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || Out !== 16'h0000 || aluOut !== prev) begin
                errors++;
                $display("FAIL mul_busy_%0d: busy=%b done=%b Out=%h aluOut=%h, want 1 0 0000 %h", i, busy, done, Out, aluOut, prev);
            end
        end
        tick();
        vectors++;
        if ({aluOut, Zero, Carry, Ovf, busy, done} !== {16'h03A8, 5'b00001}) begin
            errors++;
            $display("FAIL mul_result: aluOut=%h Z=%b C=%b O=%b busy=%b done=%b, want 03A8 0 0 0 0 1", aluOut, Zero, Carry, Ovf, busy, done);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || aluOut !== 16'h03A8) begin
            errors++;
            $display("FAIL mul_done_pulse: done=%b aluOut=%h, want 0 03A8", done, aluOut);
        end
    endtask

    task automatic test_busy_ignore;
        ACC = 16'h0003; MDR = 16'h0005;
        single(3'd7, 2'd1, 3'd2);
        for (int i = 0; i < 3; i++) tick();
        ACC = 16'h7777; MDR = 16'h1111;
        single(3'd0, 2'd0, 3'd0);
        vectors++;
        if (aluOut !== 16'h03A8 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: aluOut=%h done=%b busy=%b, want 03A8 0 1", aluOut, done, busy);
        end
        for (int i = 0; i < 11; i++) begin
            tick();
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL busy_no_extra_done_%0d: done=%b, want 0", i, done);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (aluOut !== 16'h000F || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_small_result: aluOut=%h done=%b busy=%b, want 000F 1 0", aluOut, done, busy);
        end
        tick();
        vectors++;
        if (aluOut !== 16'h000F || done !== 1'b0) begin
            errors++;
            $display("FAIL start_on_complete_ignored: aluOut=%h done=%b, want 000F 0", aluOut, done);
        end
    endtask

    task automatic test_reset_mid_mul;
        ACC = 16'h0012; MDR = 16'h0034;
        single(3'd7, 2'd1, 3'd2);
        for (int i = 0; i < 8; i++) tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || aluOut !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_mul: busy=%b done=%b aluOut=%h, want 0 0 0000", busy, done, aluOut);
        end
        #1 reset = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        PC = 16'h0010;
        single(3'd0, 2'd0, 3'd0);
        vectors++;
        if (aluOut !== 16'h0012 || done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_add: aluOut=%h done=%b, want 0012 1", aluOut, done);
        end
    endtask

    initial begin
        tick();
        tick();
        @(negedge CLK) reset = 1'b0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_back_to_back();
        test_mul(16'h0005);
        test_busy_ignore();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
